// File: rtl/bm_dag1_sym_packer_if.sv
// Symbol-in / packed-word-out bundle for the dag1 symbol packer.
// Optional flush line exists only when DAG1_PACK_FLUSH_EN is defined.
interface bm_dag1_sym_packer_if #(
  parameter int BITS = 2,
  parameter int SYMS = 4
);
  logic [BITS-1:0]      sym_in;
  logic                 sym_valid;
  logic [BITS*SYMS-1:0] word_out;
  logic                 word_valid;
  logic                 word_ready;
`ifdef DAG1_PACK_FLUSH_EN
  logic                 flush;

  modport master (
    output sym_in, sym_valid, word_ready, flush,
    input  word_out, word_valid
  );

  modport slave (
    input  sym_in, sym_valid, word_ready, flush,
    output word_out, word_valid
  );
`else
  modport master (
    output sym_in, sym_valid, word_ready,
    input  word_out, word_valid
  );

  modport slave (
    input  sym_in, sym_valid, word_ready,
    output word_out, word_valid
  );
`endif
endinterface

// File: rtl/bm_dag1_sym_packer.sv
// Packs BITS-wide symbols LSB-first into words and buffers them in a FIFO.
// Define DAG1_PACK_FLUSH_EN to add a flush input that pushes partial words.
module bm_dag1_sym_packer #(
  parameter int BITS = 2,
  parameter int SYMS = 4,
  parameter int AW   = 2
) (
  input  logic                  clock,
  input  logic                  resetn,
  bm_dag1_sym_packer_if.slave   bus,
  output logic [AW:0]           fill_level,
  output logic                  overflow
);

  localparam int W     = BITS * SYMS;
  localparam int DEPTH = 1 << AW;
  localparam int CW    = (SYMS > 1) ? $clog2(SYMS) : 1;

  typedef enum logic [1:0] {
    EMPTY,
    ACTIVE,
    FULL
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   pack_cnt;
  logic [W-1:0]    shift_q, shift_nxt;
  logic [W-1:0]    mem [DEPTH];
  logic [W-1:0]    last_q;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [AW:0]     fill_q;
  logic            last_sym, push_req;
  logic            push, pop, drop;

  always_comb begin
    shift_nxt = shift_q;
    for (int i = 0; i < SYMS; i++) begin
      if (bus.sym_valid && pack_cnt == CW'(i))
        shift_nxt[i*BITS +: BITS] = bus.sym_in;
    end
  end

  assign last_sym = bus.sym_valid &&
                    (pack_cnt == CW'(SYMS - 1));

`ifdef DAG1_PACK_FLUSH_EN
  assign push_req = last_sym ||
                    (bus.flush &&
                     (bus.sym_valid || pack_cnt != '0));
`else
  assign push_req = last_sym;
`endif

  // A pop frees the slot a same-edge push lands in.
  assign pop  = bus.word_ready && (state != EMPTY);
  assign push = push_req && ((state != FULL) || pop);
  assign drop = push_req && !push;

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: begin
        if (push)
          state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (push && !pop &&
            fill_q == (AW+1)'(DEPTH - 1))
          state_nxt = FULL;
        else if (pop && !push &&
                 fill_q == (AW+1)'(1))
          state_nxt = EMPTY;
      end
      FULL: begin
        if (pop && !push)
          state_nxt = ACTIVE;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state    <= EMPTY;
      pack_cnt <= '0;
      shift_q  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fill_q   <= '0;
      last_q   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      state <= state_nxt;
      if (push_req) begin
        pack_cnt <= '0;
        shift_q  <= '0;
      end else if (bus.sym_valid) begin
        pack_cnt <= pack_cnt + 1'b1;
        shift_q  <= shift_nxt;
      end
      if (push) begin
        mem[wr_ptr] <= shift_nxt;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        last_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      fill_q <= fill_q + (AW+1)'(push)
                       - (AW+1)'(pop);
      if (drop)
        overflow <= 1'b1;
    end
  end

  // Once drained, keep showing the word that was last handed out.
  assign bus.word_out   = (state == EMPTY) ? last_q
                                           : mem[rd_ptr];
  assign bus.word_valid = (state != EMPTY);
  assign fill_level     = fill_q;

endmodule

// File: tb/tb_bm_dag1_sym_packer.sv
// Bench for bm_dag1_sym_packer: vector table, corner sequences,
// and a queue scoreboard checking every popped word.
module tb_bm_dag1_sym_packer;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [2:0] fill_level;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  logic [7:0] q[$];
  logic [7:0] m_slots = '0;
  int         m_cnt = 0;
  logic       m_ovf = 1'b0;

  bm_dag1_sym_packer_if #(.BITS(2), .SYMS(4)) bus ();

  bm_dag1_sym_packer #(.BITS(2), .SYMS(4), .AW(2)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .bus        (bus),
    .fill_level (fill_level),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] sym;
    logic       v;
    logic       r;
    logic [2:0] fill;
    logic       wv;
    logic [7:0] word;
  } vec_t;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] s,
                       input logic v,
                       input logic r,
                       input logic f);
    bus.sym_in     = s;
    bus.sym_valid  = v;
    bus.word_ready = r;
`ifdef DAG1_PACK_FLUSH_EN
    bus.flush      = f;
`endif
  endtask

  // Called just after a negedge; returns at the next negedge.
  task automatic step(input logic [1:0] s,
                      input logic v,
                      input logic r,
                      input logic f);
    logic [7:0] w;
    bit         push;
    drive(s, v, r, f);
    chk("word_valid", 32'(bus.word_valid),
        32'(q.size() != 0));
    if (r && q.size() != 0) begin
      w = q.pop_front();
      chk("pop_word", 32'(bus.word_out), 32'(w));
    end
    push = 1'b0;
    if (v) begin
      m_slots[m_cnt*2 +: 2] = s;
      m_cnt++;
    end
    if (m_cnt == 4)
      push = 1'b1;
    if (f && m_cnt != 0)
      push = 1'b1;
    if (push) begin
      if (q.size() < 4)
        q.push_back(m_slots);
      else
        m_ovf = 1'b1;
      m_slots = '0;
      m_cnt   = 0;
    end
    @(posedge clock);
    #1;
    chk("fill", 32'(fill_level), 32'(q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    @(negedge clock);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    drive(2'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    q.delete();
    m_cnt   = 0;
    m_slots = '0;
    m_ovf   = 1'b0;
    chk("rst_word", 32'(bus.word_out), 32'h0);
    chk("rst_valid", 32'(bus.word_valid), 32'h0);
    chk("rst_fill", 32'(fill_level), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++)
      step(2'd0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    vec_t vt[6];
    vt[0] = '{2'd1, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00};
    vt[1] = '{2'd2, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00};
    vt[2] = '{2'd3, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00};
    vt[3] = '{2'd0, 1'b1, 1'b0, 3'd1, 1'b1, 8'h39};
    vt[4] = '{2'd0, 1'b0, 1'b0, 3'd1, 1'b1, 8'h39};
    vt[5] = '{2'd0, 1'b0, 1'b1, 3'd0, 1'b0, 8'h39};

    drive(2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    do_reset();

    for (int i = 0; i < 6; i++) begin
      step(vt[i].sym, vt[i].v, vt[i].r, 1'b0);
      chk($sformatf("vec%0d_fill", i),
          32'(fill_level), 32'(vt[i].fill));
      chk($sformatf("vec%0d_valid", i),
          32'(bus.word_valid), 32'(vt[i].wv));
      chk($sformatf("vec%0d_word", i),
          32'(bus.word_out), 32'(vt[i].word));
    end

    // Fill to FULL, then overflow on the fifth word.
    for (int i = 0; i < 20; i++) begin
      step(2'd3, 1'b1, 1'b0, 1'b0);
      if (i == 15) begin
        chk("full_fill", 32'(fill_level), 32'd4);
        chk("full_noovf", 32'(overflow), 32'd0);
      end
    end
    chk("ovf_fill", 32'(fill_level), 32'd4);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_head", 32'(bus.word_out), 32'hFF);

    // Push and pop together while FULL.
    step(2'd2, 1'b1, 1'b0, 1'b0);
    step(2'd2, 1'b1, 1'b0, 1'b0);
    step(2'd2, 1'b1, 1'b0, 1'b0);
    step(2'd2, 1'b1, 1'b1, 1'b0);
    chk("pp_fill", 32'(fill_level), 32'd4);
    chk("pp_ovf", 32'(overflow), 32'd1);
    drain();
    chk("last_read", 32'(bus.word_out), 32'hAA);
    chk("drained", 32'(bus.word_valid), 32'd0);

    // Ready while empty must not pop.
    step(2'd0, 1'b0, 1'b1, 1'b0);
    chk("empty_fill", 32'(fill_level), 32'd0);

    // A reset mid-word discards partial symbols.
    step(2'd3, 1'b1, 1'b0, 1'b0);
    step(2'd1, 1'b1, 1'b0, 1'b0);
    do_reset();
    step(2'd0, 1'b1, 1'b0, 1'b0);
    step(2'd0, 1'b1, 1'b0, 1'b0);
    step(2'd0, 1'b1, 1'b0, 1'b0);
    step(2'd1, 1'b1, 1'b0, 1'b0);
    chk("rst_word40", 32'(bus.word_out), 32'h40);
    chk("rst_fill1", 32'(fill_level), 32'd1);
    drain();

`ifdef DAG1_PACK_FLUSH_EN
    step(2'd2, 1'b1, 1'b0, 1'b0);
    step(2'd1, 1'b1, 1'b0, 1'b0);
    step(2'd0, 1'b0, 1'b0, 1'b1);
    chk("flush_word", 32'(bus.word_out), 32'h06);
    chk("flush_fill", 32'(fill_level), 32'd1);
    step(2'd0, 1'b0, 1'b0, 1'b1);
    chk("flush_noop", 32'(fill_level), 32'd1);
    step(2'd3, 1'b1, 1'b0, 1'b1);
    chk("flush_sym", 32'(fill_level), 32'd2);
    drain();
`endif

    // Random traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      logic [1:0] s;
      logic       v, r, f;
      s = 2'($urandom_range(0, 3));
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) == 0);
`ifdef DAG1_PACK_FLUSH_EN
      f = ($urandom_range(0, 15) == 0);
`else
      f = 1'b0;
`endif
      step(s, v, r, f);
    end
    drain();
    chk("end_empty", 32'(bus.word_valid), 32'd0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
